mdu: RTL and testbench
======================

# mdu

Multiply/divide unit in the execute stage of the pipelined MIPS core. It consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It holds the architectural HI/LO registers and raises a Busy flag that the hazard unit uses to stall MFHI/MFLO and subsequent MDU instructions. Results commit after a fixed, op-dependent latency.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for MULT/MULTU, range 1..15.
- DIV_CYCLES, default 10: busy cycles for DIV/DIVU, range 1..15.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- Reset, input, 1: synchronous, active-high; clock clk.
- Start, input, 1: request strobe, sampled only at posedge when Busy=0.
- MDOp, input, 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
- A, input, 32: rs operand (dividend / multiplicand / MT source).
- B, input, 32: rt operand (divisor / multiplier).
- HI, output, 32: architectural HI.
- LO, output, 32: architectural LO.
- Busy, output, 1: a multi-cycle op is in flight.

## Operation
- State machine has two states:
  - IDLE: Busy=0.
  - RUN: Busy=1, with a 4-bit down-counter cnt.
- IDLE, Start=1, MDOp in 0..3: latch MDOp, A and B, compute the 64-bit result into pending regs PH/PL. Load cnt with MULT_CYCLES or DIV_CYCLES, then go to RUN.
- IDLE, Start=1, MDOp=4: HI<=A on the same edge; stay IDLE. MDOp=5: LO<=A likewise.
- IDLE, Start=1, MDOp in 6..7: no effect.
- RUN: cnt decrements each edge. On the edge where cnt==1, commit HI<=PH and LO<=PL, set Busy=0, and return to IDLE.
- Start while Busy=1 is ignored for every op, including MTHI/MTLO. The hazard unit guarantees it does not occur.
- HI/LO hold their old values throughout RUN.
- MULT: signed 32x32 to 64, {PH,PL}=A*B. MULTU: the same, unsigned.
- DIV/DIVU: PL=quotient, PH=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: PL=0x80000000, PH=0.
- Divide by zero (B=0, DIV or DIVU): runs the full DIV_CYCLES with Busy=1, then commits nothing; HI/LO unchanged.
- Reset (any state): HI=0, LO=0, Busy=0, cnt=0, pending discarded, state IDLE. Reset takes priority over Start.

## Timing
- Reset values: HI=0, LO=0, Busy=0.
- Busy is registered. Start accepted at edge E gives Busy=1 from E through E+N-1 (N busy cycles), and Busy=0 after edge E+N.
- HI/LO show the new values after edge E+N, the same edge Busy falls.
- Start asserted in the first cycle with Busy=0 after a commit is accepted (back-to-back allowed).
- MTHI/MTLO latency is 1 edge; Busy is never raised.
- Outputs HI/LO/Busy are driven directly from flops; no combinational path from inputs.

## Configuration
- MDU_TRACE_EN defined:
  - Each HI write prints "$hi <= %h" and each LO write prints "$lo <= %h" via $display, in the same always block as the update. Suppressed during Reset.
  - A divide-by-zero commit prints "mdu: div by zero".
- Undefined: no display statements are compiled and behaviour is otherwise identical.

## Structure
- Shared package mdu_pkg holds:
  - MDOp encodings as localparams (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - The state encoding (ST_IDLE, ST_RUN).
  - Default latencies.
- The decoder in the controller uses the same MDOp constants.
- One sub-module, mdu_arith: purely combinational. It takes op, A and B and returns the 64-bit result plus a div0 flag, including the signed-division corner cases. The top level holds the FSM, counter and HI/LO.

## Test plan
- Reset, then MULT A=0xFFFFFFFD(-3) B=5 -> Busy=1 for 5 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFF1 on the 5th edge; MULTU same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- DIVU A=7 B=2 -> Busy 10 cycles, LO=3, HI=1; DIV A=0xFFFFFFF9(-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x1234 then DIV A=5 B=0 -> HI=0x1234 after 1 edge; Busy 10 cycles; HI=0x1234, LO unchanged after.
- MULT started, MTLO A=0xDEAD with Start on cycle 2 of RUN -> ignored; LO=product at commit; back-to-back MULT accepted the cycle after Busy falls.
- Reset asserted on cycle 3 of a DIV -> next edge HI=0, LO=0, Busy=0; no late commit occurs on later edges.
- Start with MDOp=6 -> no state change; Busy stays 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDOp encodings used by the controller decoder and the arithmetic block
//   - FSM state encoding
//   - default busy latencies
//   - small decode helpers
`timescale 1ns/1ps
package mdu_pkg;

  // MDOp encodings
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Default busy latencies (edges from accept to commit)
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ops that occupy the unit for several cycles and commit through PH/PL
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational 32x32 multiply / divide datapath.
// Ports:
//   op     [2:0]  : MDOp encoding (only MULT/MULTU/DIV/DIVU produce a result)
//   a      [31:0] : rs operand (multiplicand / dividend)
//   b      [31:0] : rt operand (multiplier / divisor)
//   result [63:0] : {HI,LO} candidate; for divides {remainder, quotient}
//   div0          : divide op with b == 0 (result is don't-care, forced to 0)
`timescale 1ns/1ps
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div0
);

  logic signed [31:0] sq;
  logic signed [31:0] sr;

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    result = '0;
    div0   = 1'b0;
    sq     = '0;
    sr     = '0;
    case (op)
      MD_MULT: begin
        result = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      end
      MD_MULTU: begin
        result = {32'b0, a} * {32'b0, b};
      end
      MD_DIV: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // -2^31 / -1 overflows; architectural result is quotient -2^31, remainder 0
          result = {32'h0000_0000, 32'h8000_0000};
        end else begin
          // SystemVerilog signed divide truncates toward zero and the
          // remainder follows the dividend's sign, matching MIPS.
          sq     = $signed(a) / $signed(b);
          sr     = $signed(a) % $signed(b);
          result = {sr, sq};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else begin
          result = {a % b, a / b};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit of the execute stage. Holds architectural HI/LO
// and a Busy flag used by the hazard unit to stall MFHI/MFLO and further
// MDU ops. Results are computed at accept time into pending PH/PL and
// committed after a fixed op-dependent latency.
// Parameters:
//   MULT_CYCLES (1..15) : busy cycles for MULT/MULTU
//   DIV_CYCLES  (1..15) : busy cycles for DIV/DIVU
// Ports:
//   clk          : clock, rising edge
//   Reset        : synchronous, active-high
//   Start        : request strobe, honoured only while Busy=0
//   MDOp  [2:0]  : operation (see mdu_pkg)
//   A     [31:0] : rs operand
//   B     [31:0] : rt operand
//   HI    [31:0] : architectural HI (flop output)
//   LO    [31:0] : architectural LO (flop output)
//   Busy         : multi-cycle op in flight (flop output)
// Build option: define MDU_TRACE_EN to print every HI/LO write and
// divide-by-zero completions.
`timescale 1ns/1ps
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  state_e      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        busy_n;

  logic [31:0] ph, pl;
  logic        pdiv0;

  logic [63:0] arith_res;
  logic        arith_div0;

  logic        pend_we;
  logic        hi_we, lo_we;
  logic [31:0] hi_d, lo_d;
  logic        div0_commit;

  mdu_arith u_arith (
    .op     (MDOp),
    .a      (A),
    .b      (B),
    .result (arith_res),
    .div0   (arith_div0)
  );

  // Next-state / control decode
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    busy_n      = Busy;
    pend_we     = 1'b0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    hi_d        = ph;
    lo_d        = pl;
    div0_commit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          if (is_muldiv(MDOp)) begin
            pend_we = 1'b1;
            state_n = ST_RUN;
            busy_n  = 1'b1;
            cnt_n   = is_div(MDOp) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          end else if (MDOp == MD_MTHI) begin
            hi_we = 1'b1;
            hi_d  = A;
          end else if (MDOp == MD_MTLO) begin
            lo_we = 1'b1;
            lo_d  = A;
          end
          // reserved encodings fall through with no effect
        end
      end
      ST_RUN: begin
        // Start is deliberately not looked at here: the hazard unit never
        // issues while Busy, and any stray request is dropped.
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          if (pdiv0) begin
            div0_commit = 1'b1;
          end else begin
            hi_we = 1'b1;
            lo_we = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      Busy  <= busy_n;
    end
  end

  // HI/LO and pending result registers
  // NOTE: the pending registers are reset along with HI/LO so an aborted op
  // leaves nothing behind that could ever be committed later.
  always_ff @(posedge clk) begin
    if (Reset) begin
      HI    <= '0;
      LO    <= '0;
      ph    <= '0;
      pl    <= '0;
      pdiv0 <= 1'b0;
    end else begin
      if (pend_we) begin
        ph    <= arith_res[63:32];
        pl    <= arith_res[31:0];
        pdiv0 <= arith_div0;
      end
      if (hi_we) HI <= hi_d;
      if (lo_we) LO <= lo_d;
`ifdef MDU_TRACE_EN
      if (hi_we)       $display("$hi <= %h", hi_d);
      if (lo_we)       $display("$lo <= %h", lo_d);
      if (div0_commit) $display("mdu: div by zero");
`else
      // tracing compiled out
`endif
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu. The driver computes each op's expected
// HI/LO from plain 64-bit arithmetic and queues it; a monitor pops at the
// accept edge and checks Busy and HI/LO on each following negedge.
`timescale 1ns/1ps
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] HI, LO;
  logic        Busy;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .Reset (Reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .HI    (HI),
    .LO    (LO),
    .Busy  (Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;     // busy cycles expected after the accept edge
    logic [31:0] hi;    // HI after completion
    logic [31:0] lo;    // LO after completion
    int          hold;  // extra idle cycles over which values must stay put
  } item_t;

  item_t       sb_q[$];
  item_t       mon_it;
  logic        mon_active = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;   // monitor's view of committed HI/LO
  logic [31:0] exp_hi = '0, exp_lo = '0; // driver's reference model
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Called aligned to a negedge; returns just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv;
    logic [63:0] p;
    item_t       it;
    int          n;
    n = 0;
    case (op)
      3'd0: begin
        sa = longint'($signed(a)); sbv = longint'($signed(b));
        p = sa * sbv; exp_hi = p[63:32]; exp_lo = p[31:0]; n = MC;
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; n = MC;
      end
      3'd2: begin
        n = DC;
        if (b != 0) begin
          sa = longint'($signed(a)); sbv = longint'($signed(b));
          exp_lo = 32'(sa / sbv); exp_hi = 32'(sa % sbv);
        end
      end
      3'd3: begin
        n = DC;
        if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
    it = '{n, exp_hi, exp_lo, 0};
    Start = 1'b1; MDOp = op; A = a; B = b;
    sb_q.push_back(it);
    @(posedge clk);
    #1 Start = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !mon_active) begin done = 1; break; end
    end
    check("idle_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < 40 && Busy; i++) @(negedge clk);
    check("busy_timeout", {31'b0, Busy}, 32'd0);
  endtask

  // Monitor: pops at the accept edge, then follows the op to completion.
  initial begin
    forever begin
      @(posedge clk);
      if (sb_q.size() > 0) begin
        mon_it = sb_q.pop_front();
        mon_active = 1'b1;
        for (int i = 0; i < mon_it.n; i++) begin
          @(negedge clk);
          check("busy_run", {31'b0, Busy}, 32'd1);
          check("hi_hold", HI, m_hi);
          check("lo_hold", LO, m_lo);
          @(posedge clk);
        end
        @(negedge clk);
        check("busy_done", {31'b0, Busy}, 32'd0);
        check("hi_result", HI, mon_it.hi);
        check("lo_result", LO, mon_it.lo);
        m_hi = mon_it.hi;
        m_lo = mon_it.lo;
        for (int i = 0; i < mon_it.hold; i++) begin
          @(negedge clk);
          check("busy_quiet", {31'b0, Busy}, 32'd0);
          check("hi_quiet", HI, m_hi);
          check("lo_quiet", LO, m_lo);
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    item_t it;
    // Reset
    repeat (3) @(posedge clk);
    #1 Reset = 1'b0;
    @(negedge clk);
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);
    check("reset_busy", {31'b0, Busy}, 32'd0);

    // Directed multiply / divide cases
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);          wait_idle();
    issue(3'd1, 32'hFFFF_FFFD, 32'd5);          wait_idle();
    issue(3'd3, 32'd7, 32'd2);                  wait_idle();
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);          wait_idle();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);  wait_idle();

    // MTHI then divide by zero, back to back
    issue(3'd4, 32'h0000_1234, 32'd0);
    @(negedge clk);
    issue(3'd2, 32'd5, 32'd0);                  wait_idle();
    issue(3'd3, 32'd9, 32'd0);                  wait_idle();

    // MTLO during RUN is dropped; back-to-back MULT after Busy falls
    issue(3'd0, 32'h0001_0003, 32'hFFFF_0007);
    @(negedge clk);
    @(negedge clk);
    Start = 1'b1; MDOp = 3'd5; A = 32'h0000_DEAD; B = 32'd0;
    @(posedge clk);
    #1 Start = 1'b0;
    @(negedge clk);
    wait_not_busy();
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);  wait_idle();

    // Reserved op: nothing changes, Busy never rises
    issue(3'd6, 32'hFFFF_FFFF, 32'h1);          wait_idle();
    issue(3'd7, 32'h5555_5555, 32'h2);          wait_idle();

    // Randomized ops
    for (int k = 0; k < 30; k++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 1) == 0) wait_idle();
      else begin @(negedge clk); wait_not_busy(); end
    end
    wait_idle();

    // Reset during cycle 3 of a DIV: cleared immediately, no late commit
    exp_hi = 32'h0; exp_lo = 32'h0;
    it = '{3, 32'h0, 32'h0, 12};
    Start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd7;
    sb_q.push_back(it);
    @(posedge clk);
    #1 Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    wait_idle();

    // Unit still works after a mid-op reset
    issue(3'd3, 32'd100, 32'd7);                wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
